// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and its round-robin picker.
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 12;
    localparam int N_CORES_MAX = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    // Successor of idx in a ring of n entries.
    function automatic int ring_next(input int idx, input int n);
        int nxt;
        nxt = idx + 1;
        if (nxt >= n) begin
            nxt = 0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int N     = N_CORES_MAX,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;

    // Walk the ring from ptr; the first requester seen wins.
    always_comb begin
        found  = 1'b0;
        index  = '0;
        sum_s  = '0;
        cand_s = '0;
        for (int off = 0; off < N; off++) begin
            sum_s = {1'b0, ptr} + (IDX_W+1)'(off);
            if (sum_s >= (IDX_W+1)'(N)) begin
                sum_s = sum_s - (IDX_W+1)'(N);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDX_W-1:0];
            if (!found && req[cand_s]) begin
                found = 1'b1;
                index = cand_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory between N_CORES cores,
// plus sticky aggregation of per-core end_process into all_done.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CORES-1:0]        req,
    input  logic [N_CORES-1:0]        we,
    input  logic [N_CORES*ADDR_W-1:0] addr,
    input  logic [N_CORES*DATA_W-1:0] wdata,
    input  logic [N_CORES-1:0]        end_process,
    input  logic                      start,
    output logic [N_CORES-1:0]        grant,
    output logic [N_CORES-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      all_done
);

    localparam int                 IDX_W     = $clog2(N_CORES);
    localparam logic [N_CORES-1:0] ONE_HOT_0 = N_CORES'(1);

    arb_state_e         state_r, state_s;
    logic [IDX_W-1:0]   ptr_r, sel_r, pick_idx_s, ptr_next_s;
    logic               pick_found_s, pick_we_s;
    logic [ADDR_W-1:0]  pick_addr_s, mem_addr_r;
    logic [DATA_W-1:0]  pick_wdata_s, mem_wdata_r, rdata_r;
    logic [N_CORES-1:0] grant_r, rvalid_r, done_r, done_s;
    logic               mem_we_r, all_done_r;

    rr_pick #(.N(N_CORES), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .index (pick_idx_s)
    );

    assign ptr_next_s = IDX_W'(ring_next(int'(sel_r), N_CORES));

    // Select the winning core's request fields.
    always_comb begin
        pick_addr_s  = '0;
        pick_wdata_s = '0;
        pick_we_s    = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            if (IDX_W'(i) == pick_idx_s) begin
                pick_addr_s  = addr[i*ADDR_W +: ADDR_W];
                pick_wdata_s = wdata[i*DATA_W +: DATA_W];
                pick_we_s    = we[i];
            end else begin
            end
        end
    end

    // Next-state logic; a write finishes in ACCESS, a read waits for memory.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (mem_we_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = RDWAIT;
                end
            end
            RDWAIT:  state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered memory port, grant/rvalid pulses and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= '0;
            sel_r       <= '0;
            grant_r     <= '0;
            rvalid_r    <= '0;
            rdata_r     <= '0;
            mem_addr_r  <= '0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= '0;
        end else begin
            grant_r  <= '0;
            rvalid_r <= '0;
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        sel_r       <= pick_idx_s;
                        mem_addr_r  <= pick_addr_s;
                        mem_wdata_r <= pick_wdata_s;
                        mem_we_r    <= pick_we_s;
                        grant_r     <= ONE_HOT_0 << pick_idx_s;
                    end else begin
                        mem_we_r <= 1'b0;
                    end
                end
                ACCESS: begin
                    mem_we_r <= 1'b0;
                    if (mem_we_r) begin
                        ptr_r <= ptr_next_s;
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                RDWAIT: begin
                    rdata_r  <= mem_rdata;
                    rvalid_r <= ONE_HOT_0 << sel_r;
                end
                RESP: begin
                    ptr_r <= ptr_next_s;
                end
                default: begin
                    mem_we_r <= 1'b0;
                end
            endcase
        end
    end

    // start wins over a coincident end_process.
    always_comb begin
        if (start) begin
            done_s = '0;
        end else begin
            done_s = done_r | end_process;
        end
    end

    // Sticky done vector and its registered AND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r     <= '0;
            all_done_r <= 1'b0;
        end else begin
            done_r     <= done_s;
            all_done_r <= &done_s;
        end
    end

    assign grant     = grant_r;
    assign rvalid    = rvalid_r;
    assign rdata     = rdata_r;
    assign mem_addr  = mem_addr_r;
    assign mem_we    = mem_we_r;
    assign mem_wdata = mem_wdata_r;
    assign all_done  = all_done_r;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one 12-bit data memory between N_CORES processor instances in a multi-core build.
- Each core requests a single read or write; a round-robin scheduler grants one access at a time and drives the single memory port.
- Returns read data to the granted core.
- Aggregates each core's end_process into a sticky all_done flag for the top level.

Parameters:
N_CORES, 4, number of requesting cores (2..8)
ADDR_W, 12, data-memory address width
DATA_W, 12, data-memory word width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N_CORES  per-core access request, level, held until grant
we  in  N_CORES  per-core write flag (1=write, 0=read), valid with req
addr  in  N_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
wdata  in  N_CORES*DATA_W  per-core write data, same packing
end_process  in  N_CORES  per-core completion pulse/level
start  in  1  clears done tracking for a new run
grant  out  N_CORES  one-hot, one-cycle pulse: request accepted
rvalid  out  N_CORES  one-hot, one-cycle pulse: rdata valid for core i
rdata  out  DATA_W  read data, shared by all cores, qualified by rvalid
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable (dm_en)
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, one-cycle synchronous latency
all_done  out  1  every core has signalled end_process since last start/reset

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, ptr=0, sel=0.
  - grant=0, rvalid=0, rdata=0.
  - mem_addr=0, mem_we=0, mem_wdata=0.
  - done vector=0, all_done=0.
- Reset mid-access aborts the access; mem_we drops immediately. No grant or rvalid is issued after release.
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE:
  - If any req is set, select the first set bit scanning ptr, ptr+1, ... with wrap modulo N_CORES. Latch sel.
  - Register mem_addr, mem_wdata and mem_we=we[sel]. Go to ACCESS.
  - If no req, stay in IDLE with mem_we=0.
- ACCESS (1 cycle):
  - Memory port is presented; grant[sel]=1 in this cycle.
  - If a write, the memory writes at the end of this cycle. Set ptr=(sel+1) mod N_CORES and go to IDLE.
  - If a read, go to RDWAIT.
- RDWAIT (1 cycle): mem_we=0; on exit, rdata<=mem_rdata. Go to RESP.
- RESP (1 cycle): rvalid[sel]=1, rdata stable. Set ptr=(sel+1) mod N_CORES and go to IDLE.
- Latency, counting the cycle req is first sampled in IDLE as T:
  - grant at T+1.
  - Read rvalid at T+3.
  - Write throughput: 1 per 2 cycles. Read throughput: 1 per 4 cycles.
- Requester rules:
  - Hold req, we, addr and wdata until grant.
  - Deassert req in the cycle after grant, or keep it high to queue another access; a held req is re-arbitrated.
  - A req dropped before grant is withdrawn silently.
- Fairness: a continuously requesting core waits at most N_CORES-1 accesses. ptr wraps from N_CORES-1 to 0.
- mem_addr and mem_wdata hold their last value between accesses. mem_we is high only in ACCESS for a write.
- Done tracking:
  - done[i] sets on end_process[i]=1 and stays set; all_done=&done, registered.
  - start=1 clears done and all_done next cycle; start has priority over a simultaneous end_process.
  - The arbiter keeps serving requests regardless of all_done.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, FSM state encoding (IDLE, ACCESS, RDWAIT, RESP), N_CORES_MAX=8.
- One sub-module, rr_pick: combinational; inputs req vector and ptr; outputs found and index. Reused by any future shared-resource arbiter.

Test Plan:
- Single read: core 1 req, we=0, addr=12'h010, memory holds 12'h0AB -> grant[1] at T+1, mem_addr=010 with mem_we=0, rvalid[1] at T+3 with rdata=0AB.
- Single write: core 0 req, we=1, addr=12'h005, wdata=12'h123 -> grant[0] and mem_we=1 at T+1 only; a later read of 005 returns 123.
- Contention: all 4 cores request continuously from ptr=0 -> grant order 0,1,2,3,0 with no core granted twice before others.
- ptr wrap: after core 3 is served, requests from cores 0 and 3 -> core 0 is granted first.
- Reset mid-read: rst_n low during RDWAIT -> all outputs 0 immediately; after release, no rvalid and state IDLE.
- Done tracking: end_process pulses on cores 0..3 at different cycles -> all_done rises the cycle after the last pulse. start=1 -> all_done=0 next cycle. start coincident with end_process[2] -> done[2] stays 0.
